timing_sequence_counter: RTL

//  Sequence counter (SC) and run-control FSM for the common-bus basic computer.
//  sc_count drives the 4x16 timing decoder that produces T0..T15. The control unit

---
 rtl/timing_sequence_counter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/timing_sequence_counter.sv
// ----------------------------------------------------------------------------
// timing_sequence_counter
//
// Sequence counter (SC) plus run-control FSM for the common-bus basic
// computer. sc_count feeds the timing decoder that produces T0..T(2**W-1).
// The control unit clears SC at the end of every instruction with sc_clr.
// Supports free-run, single-step, wait-state hold and halt.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (overrides all other inputs)
//   start        level; IDLE/HALT -> RUN (or STEP when step_mode=1)
//   step_mode    sampled only on an accepted start; 1 = single-step
//   step_pulse   in STEP, advance SC by one in this cycle
//   sc_hold      wait state; freezes SC in RUN/STEP
//   sc_clr       end of instruction; SC <- 0 next cycle
//   halt_req     HLT instruction / operator stop
//   sc_count     current timing state (registered)
//   running      1 in RUN or STEP (registered)
//   halted       1 in HALT (registered)
//   instr_done   one-cycle pulse after an accepted sc_clr
//   instr_count  accepted sc_clr count since reset, wraps silently
//   sc_overflow  sticky; SC wrapped all-ones -> 0 without an sc_clr
// ----------------------------------------------------------------------------
module timing_sequence_counter #(
   parameter int CNT_WIDTH = 4,
   parameter int IC_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 step_mode,
   input  logic                 step_pulse,
   input  logic                 sc_hold,
   input  logic                 sc_clr,
   input  logic                 halt_req,
   output logic [CNT_WIDTH-1:0] sc_count,
   output logic                 running,
   output logic                 halted,
   output logic                 instr_done,
   output logic [IC_WIDTH-1:0]  instr_count,
   output logic                 sc_overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] SC_MAX = {CNT_WIDTH{1'b1}};

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] sc_nxt;
   logic                 done_nxt;
   logic [IC_WIDTH-1:0]  ic_nxt;
   logic                 ovf_nxt;
   logic                 advance;

   // State register and all outputs are flops; running/halted are registered
   // decodes of the next state so they line up with the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sc_count    <= '0;
         running     <= 1'b0;
         halted      <= 1'b0;
         instr_done  <= 1'b0;
         instr_count <= '0;
         sc_overflow <= 1'b0;
      end else begin
         state       <= state_nxt;
         sc_count    <= sc_nxt;
         running     <= (state_nxt == RUN) || (state_nxt == STEP);
         halted      <= (state_nxt == HALT);
         instr_done  <= done_nxt;
         instr_count <= ic_nxt;
         sc_overflow <= ovf_nxt;
      end
   end

   // Next-state / SC update. In RUN/STEP exactly one action applies per cycle:
   // halt_req, then sc_clr, then sc_hold, then advance.
   always_comb begin
      state_nxt = state;
      sc_nxt    = sc_count;
      done_nxt  = 1'b0;
      ic_nxt    = instr_count;
      ovf_nxt   = sc_overflow;
      advance   = 1'b0;

      unique case (state)
         IDLE: begin
            sc_nxt = '0;
            if (start) state_nxt = step_mode ? STEP : RUN;
         end

         RUN, STEP: begin
            if (halt_req) begin
               // A coincident sc_clr is dropped: the instruction did not retire.
               state_nxt = HALT;
            end else if (sc_clr) begin
               sc_nxt   = '0;
               done_nxt = 1'b1;
               ic_nxt   = instr_count + 1'b1;
            end else if (!sc_hold) begin
               advance = (state == RUN) || step_pulse;
            end
            if (advance) begin
               sc_nxt = sc_count + 1'b1;
               if (sc_count == SC_MAX) ovf_nxt = 1'b1;
            end
         end

         HALT: begin
            // Restart always begins a fresh instruction at T0.
            if (start) begin
               sc_nxt    = '0;
               state_nxt = step_mode ? STEP : RUN;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
